// File: rtl/sram_sp_access_ctrl_pkg.sv
// Shared types and helpers for the single-port SRAM access controller.
package sram_sp_access_ctrl_pkg;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_e;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_WR,
        GNT_RD
    } grant_e;

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/sram_rsp_fifo.sv
// Show-ahead response FIFO; the head entry is presented on data while valid.
module sram_rsp_fifo
    import sram_sp_access_ctrl_pkg::*;
#(
    parameter int WIDTH     = 128,
    parameter int RSP_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    localparam int PtrW = $clog2(RSP_DEPTH);
    localparam int CntW = cnt_width(RSP_DEPTH);

    logic [WIDTH-1:0] mem_q [RSP_DEPTH];
    logic [WIDTH-1:0] mem_d [RSP_DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             do_pop;

    function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
        return (p == PtrW'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign valid  = (count_q != '0);
    assign do_pop = pop && valid;
    // Gate the head so a flushed FIFO shows zero rather than stale storage.
    assign data   = valid ? mem_q[rd_ptr_q] : '0;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = next_ptr(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = next_ptr(rd_ptr_q);
        end
        unique case ({push, do_pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/sram_sp_access_ctrl.sv
// Single-port SRAM front end: arbitrates write/read channels onto registered macro pins.
// Define SRAM_SP_ACCESS_CTRL_ZERO_INIT_EN to zero every row after reset.
module sram_sp_access_ctrl
    import sram_sp_access_ctrl_pkg::*;
#(
    parameter  int WIDTH        = 128,
    parameter  int NUM_ROWS     = 4096,
    parameter  int RSP_DEPTH    = 4,
    localparam int AddressWidth = $clog2(NUM_ROWS)
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    input  logic [AddressWidth-1:0] wr_addr,
    input  logic [WIDTH-1:0]        wr_data,
    input  logic [WIDTH-1:0]        wr_mask,
    input  logic                    rd_valid,
    output logic                    rd_ready,
    input  logic [AddressWidth-1:0] rd_addr,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [WIDTH-1:0]        rsp_data,
    output logic                    CEB,
    output logic                    WEB,
    output logic [AddressWidth-1:0] A,
    output logic [WIDTH-1:0]        D,
    output logic [WIDTH-1:0]        M,
    input  logic [WIDTH-1:0]        Q,
    output logic                    init_done
);

    localparam int CntW = cnt_width(RSP_DEPTH);

    state_e                  state_q, state_d;
    grant_e                  rr_last_q, rr_last_d;
    grant_e                  gnt;
    logic [CntW-1:0]         outst_q, outst_d;
    logic                    ceb_q, ceb_d;
    logic                    web_q, web_d;
    logic [AddressWidth-1:0] a_q, a_d;
    logic [WIDTH-1:0]        d_q, d_d;
    logic [WIDTH-1:0]        m_q, m_d;
    logic                    rd_s1_q, rd_s1_d;
    logic                    rd_s2_q, rd_s2_d;
    logic                    rd_allowed;
    logic                    rsp_hs;
`ifdef SRAM_SP_ACCESS_CTRL_ZERO_INIT_EN
    logic [AddressWidth-1:0] row_q, row_d;
`endif

    assign rd_allowed = (outst_q < CntW'(RSP_DEPTH));
    assign rsp_hs     = rsp_valid && rsp_ready;
    assign init_done  = (state_q == ST_RUN);

    // Round-robin only matters on a tie; a blocked read never stalls writes.
    always_comb begin
        gnt = GNT_NONE;
        if (state_q == ST_RUN) begin
            if (wr_valid && rd_valid && rd_allowed) begin
                gnt = (rr_last_q == GNT_WR) ? GNT_RD : GNT_WR;
            end else if (wr_valid) begin
                gnt = GNT_WR;
            end else if (rd_valid && rd_allowed) begin
                gnt = GNT_RD;
            end
        end
        wr_ready = (gnt == GNT_WR);
        rd_ready = (gnt == GNT_RD);
    end

    always_comb begin
        state_d   = state_q;
        rr_last_d = rr_last_q;
        ceb_d     = 1'b1;
        web_d     = 1'b1;
        a_d       = a_q;
        d_d       = d_q;
        m_d       = m_q;
        rd_s1_d   = 1'b0;
        rd_s2_d   = rd_s1_q;
`ifdef SRAM_SP_ACCESS_CTRL_ZERO_INIT_EN
        row_d     = row_q;
        if (state_q == ST_INIT) begin
            ceb_d = 1'b0;
            web_d = 1'b0;
            a_d   = row_q;
            d_d   = '0;
            m_d   = '1;
            row_d = row_q + 1'b1;
            if (row_q == AddressWidth'(NUM_ROWS - 1)) begin
                row_d   = '0;
                state_d = ST_RUN;
            end
        end
`else
        if (state_q == ST_INIT) begin
            state_d = ST_RUN;
        end
`endif
        unique case (gnt)
            GNT_WR: begin
                ceb_d     = 1'b0;
                web_d     = 1'b0;
                a_d       = wr_addr;
                d_d       = wr_data;
                m_d       = wr_mask;
                rr_last_d = GNT_WR;
            end
            GNT_RD: begin
                ceb_d     = 1'b0;
                a_d       = rd_addr;
                rd_s1_d   = 1'b1;
                rr_last_d = GNT_RD;
            end
            default: ;
        endcase
        // Credits span the pin/capture pipeline and the FIFO itself.
        unique case ({gnt == GNT_RD, rsp_hs})
            2'b10:   outst_d = outst_q + CntW'(1);
            2'b01:   outst_d = outst_q - CntW'(1);
            default: outst_d = outst_q;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= ST_INIT;
            rr_last_q <= GNT_RD;
            outst_q   <= '0;
            ceb_q     <= 1'b1;
            web_q     <= 1'b1;
            a_q       <= '0;
            d_q       <= '0;
            m_q       <= '0;
            rd_s1_q   <= 1'b0;
            rd_s2_q   <= 1'b0;
`ifdef SRAM_SP_ACCESS_CTRL_ZERO_INIT_EN
            row_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            rr_last_q <= rr_last_d;
            outst_q   <= outst_d;
            ceb_q     <= ceb_d;
            web_q     <= web_d;
            a_q       <= a_d;
            d_q       <= d_d;
            m_q       <= m_d;
            rd_s1_q   <= rd_s1_d;
            rd_s2_q   <= rd_s2_d;
`ifdef SRAM_SP_ACCESS_CTRL_ZERO_INIT_EN
            row_q     <= row_d;
`endif
        end
    end

    assign CEB = ceb_q;
    assign WEB = web_q;
    assign A   = a_q;
    assign D   = d_q;
    assign M   = m_q;

    sram_rsp_fifo #(
        .WIDTH     (WIDTH),
        .RSP_DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk       (CLK),
        .rst       (RST),
        .push      (rd_s2_q),
        .push_data (Q),
        .pop       (rsp_ready),
        .valid     (rsp_valid),
        .data      (rsp_data)
    );

endmodule

// File: tb/tb_sram_sp_access_ctrl.sv
// Scoreboard bench: array memory model predicts read data at accept time.
module tb_sram_sp_access_ctrl;

    localparam int W  = 16;
    localparam int NR = 16;
    localparam int RD = 4;
    localparam int AW = $clog2(NR);
`ifdef SRAM_SP_ACCESS_CTRL_ZERO_INIT_EN
    localparam int INIT_EDGES = NR;
`else
    localparam int INIT_EDGES = 1;
`endif
    localparam logic [W-1:0] ONES = '1;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic [AW-1:0] wr_addr = '0;
    logic [W-1:0]  wr_data = '0;
    logic [W-1:0]  wr_mask = '0;
    logic          rd_valid = 1'b0;
    logic          rd_ready;
    logic [AW-1:0] rd_addr = '0;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [W-1:0]  rsp_data;
    logic          CEB, WEB;
    logic [AW-1:0] A;
    logic [W-1:0]  D, M;
    logic [W-1:0]  Q = '0;
    logic          init_done;

    int checks = 0;
    int failures = 0;
    int mode = 0;
    logic [W-1:0] exp_q [$];
    logic [W-1:0] ref_mem [NR];
    logic [W-1:0] macro_mem [NR];

    always #5 CLK = ~CLK;

    sram_sp_access_ctrl #(
        .WIDTH(W), .NUM_ROWS(NR), .RSP_DEPTH(RD)
    ) dut (
        .CLK(CLK), .RST(RST),
        .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_mask(wr_mask),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .CEB(CEB), .WEB(WEB), .A(A), .D(D), .M(M), .Q(Q),
        .init_done(init_done)
    );

    // Behavioural single-port macro with 1-cycle synchronous read.
    always @(posedge CLK) begin
        if (!CEB) begin
            if (!WEB) macro_mem[A] <= (macro_mem[A] & ~M) | (D & M);
            else      Q <= macro_mem[A];
        end
    end

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: drives rsp_ready and scores every response handshake.
    initial begin
        logic [W-1:0] e;
        rsp_ready = 1'b0;
        forever begin
            @(negedge CLK);
            case (mode)
                0:       rsp_ready = 1'b1;
                1:       rsp_ready = 1'($urandom_range(0, 1));
                default: rsp_ready = 1'b0;
            endcase
            #1;
            if (rsp_valid && rsp_ready && !RST) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL rsp_unexpected actual=%0h expected=none",
                             rsp_data);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_data", rsp_data, e);
                end
            end
        end
    end

    task automatic cycle(input logic wv, input logic [AW-1:0] wa,
                         input logic [W-1:0] wd, input logic [W-1:0] wm,
                         input logic rv, input logic [AW-1:0] ra,
                         output logic wacc, output logic racc);
        @(negedge CLK);
        wr_valid = wv; wr_addr = wa; wr_data = wd; wr_mask = wm;
        rd_valid = rv; rd_addr = ra;
        #2;
        check("one_grant", 64'(wr_ready && rd_ready), 0);
        wacc = wv && wr_ready;
        racc = rv && rd_ready;
        if (wacc) ref_mem[wa] = (ref_mem[wa] & ~wm) | (wd & wm);
        if (racc) exp_q.push_back(ref_mem[ra]);
        @(posedge CLK);
    endtask

    task automatic idle(input int n);
        logic wa, ra;
        repeat (n) cycle(0, '0, '0, '0, 0, '0, wa, ra);
    endtask

    task automatic wait_init();
        int n = 0;
        while (!init_done && n < NR + 8) begin
            @(posedge CLK);
            #1;
            n++;
`ifdef SRAM_SP_ACCESS_CTRL_ZERO_INIT_EN
            if (n <= NR) begin
                check("sweep_pins", {CEB, WEB, 4'(A), D, M},
                      {1'b0, 1'b0, 4'(n - 1), {W{1'b0}}, ONES});
            end
`endif
        end
        check("init_edges", n, INIT_EDGES);
    endtask

    task automatic clear_ref();
`ifdef SRAM_SP_ACCESS_CTRL_ZERO_INIT_EN
        for (int i = 0; i < NR; i++) ref_mem[i] = '0;
`endif
    endtask

    initial begin
        logic wa, ra;
        int acc;
        for (int i = 0; i < NR; i++) ref_mem[i] = '0;

        // Reset with both requests pending: nothing may be granted.
        wr_valid = 1'b1;
        rd_valid = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        check("rst_ceb", CEB, 1);
        check("rst_web", WEB, 1);
        check("rst_a", A, 0);
        check("rst_d", D, 0);
        check("rst_m", M, 0);
        check("rst_wr_ready", wr_ready, 0);
        check("rst_rd_ready", rd_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_init_done", init_done, 0);
        @(negedge CLK);
        wr_valid = 1'b0;
        rd_valid = 1'b0;
        RST = 1'b0;
        clear_ref();
        wait_init();

`ifdef SRAM_SP_ACCESS_CTRL_ZERO_INIT_EN
        cycle(0, '0, '0, '0, 1, 4'd9, wa, ra);
        check("row9_acc", ra, 1);
        idle(3);
`endif
        for (int i = 0; i < NR; i++) begin
            cycle(1, AW'(i), W'($urandom), ONES, 0, '0, wa, ra);
            check("preload_acc", wa, 1);
        end
        idle(2);

        // Write row 5 then read it back; check pin and response timing.
        cycle(1, 4'd5, 16'h00A5, ONES, 0, '0, wa, ra);
        #1;
        check("wr_pins", {CEB, WEB, 4'(A), D}, {2'b00, 4'd5, 16'h00A5});
        cycle(0, '0, '0, '0, 1, 4'd5, wa, ra);
        #1;
        check("rd_pins", {CEB, WEB, 4'(A)}, {2'b01, 4'd5});
        check("rsp_lat0", rsp_valid, 0);
        idle(1);
        #1;
        check("rsp_lat1", rsp_valid, 0);
        idle(1);
        #1;
        check("rsp_lat2", rsp_valid, 1);
        idle(3);

        // Partial mask on row 7: 0xFF then clear the low nibble.
        cycle(1, 4'd7, 16'h00FF, ONES, 0, '0, wa, ra);
        cycle(1, 4'd7, 16'h0000, 16'h000F, 0, '0, wa, ra);
        cycle(0, '0, '0, '0, 1, 4'd7, wa, ra);
        idle(4);

        // Both channels held: grants alternate starting with write.
        for (int i = 0; i < 8; i++) begin
            cycle(1, AW'($urandom), W'($urandom), W'($urandom),
                  1, AW'($urandom), wa, ra);
            check("alt_grant", {wa, ra}, (i % 2 == 0) ? 2'b10 : 2'b01);
        end
        idle(5);

        // Reset one cycle after a read accept drops the read.
        cycle(0, '0, '0, '0, 1, 4'd3, wa, ra);
        @(negedge CLK);
        RST = 1'b1;
        @(posedge CLK);
        #1;
        check("mid_rst_ceb", CEB, 1);
        check("mid_rst_rsp_valid", rsp_valid, 0);
        exp_q.delete();
        @(negedge CLK);
        RST = 1'b0;
        clear_ref();
        wait_init();
        for (int i = 0; i < 3; i++) begin
            idle(1);
            #1;
            check("mid_rst_no_rsp", rsp_valid, 0);
        end

        // Backpressure: only RSP_DEPTH reads may be outstanding.
        mode = 2;
        acc = 0;
        for (int i = 0; i < 10; i++) begin
            cycle(0, '0, '0, '0, 1, AW'($urandom), wa, ra);
            if (ra) acc++;
        end
        check("bp_accepts", acc, RD);
        check("bp_blocked", ra, 0);
        mode = 0;
        cycle(0, '0, '0, '0, 1, AW'($urandom), wa, ra);
        check("bp_pop_cycle", ra, 0);
        cycle(0, '0, '0, '0, 1, AW'($urandom), wa, ra);
        check("bp_reassert", ra, 1);
        idle(8);

        // Randomized traffic with random response backpressure.
        mode = 1;
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 1)), AW'($urandom), W'($urandom),
                  W'($urandom), 1'($urandom_range(0, 1)), AW'($urandom),
                  wa, ra);
        end

        mode = 0;
        acc = 0;
        while (exp_q.size() != 0 && acc < 64) begin
            idle(1);
            acc++;
        end
        check("drain", exp_q.size(), 0);
        idle(3);
        #1;
        check("final_idle", rsp_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
